nes_pad_reader: RTL
===================

Name: nes_pad_reader

Overview:
- Sequences the NES controller shift-register read on a 40 MHz clock, once per 60 Hz poll period.
- Generates the latch pulse and the serial clock pulses, samples the active-low serial data line and presents a registered, active-high 8-bit button vector with a one-cycle valid strobe.
- Replaces ad-hoc latch/pulse generation; sits between the controller pins and game logic.

Parameters:
- POLL_CYCLES, 666666, clk cycles per poll period (16.67 ms at 40 MHz).
- LATCH_CYCLES, 480, latch high time in clk cycles (12 us).
- HALF_CYCLES, 240, pulse half-period in clk cycles (6 us).
- NUM_BUTTONS, 8, bits read per poll.

Ports:
- clk  input  1  40 MHz system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  polling enable; sampled only at poll tick
- button_data  input  1  serial data from controller, active-low (0 = pressed)
- latch  output  1  controller latch, registered
- pulse  output  1  controller serial clock, registered
- buttons  output  NUM_BUTTONS  active-high button state: bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right
- buttons_valid  output  1  one-cycle strobe when buttons updates
- busy  output  1  high while a read sequence is in progress

Behaviour:
- Reset (reset=0, async): latch=0, pulse=0, buttons=0, buttons_valid=0, busy=0; poll timer=0; FSM=IDLE; shift register=0. Effective immediately, including mid-sequence; no partial result is ever published.
- Poll timer: free-running 0..POLL_CYCLES-1, width $clog2(POLL_CYCLES); tick when timer==POLL_CYCLES-1, then wraps to 0. Runs regardless of enable.
- FSM states: IDLE, LATCH, PULSE_LO, PULSE_HI, DONE.
- IDLE: on tick with enable=1, go to LATCH. Tick with enable=0 is ignored.
- LATCH: latch=1 for exactly LATCH_CYCLES cycles. On the final latch cycle's edge, sample button_data into bit 0; latch falls on the same edge. Go to PULSE_LO with bit index=1.
- PULSE_LO: pulse=0 for HALF_CYCLES cycles, then PULSE_HI.
- PULSE_HI: pulse=1 for HALF_CYCLES cycles. On the final high cycle's edge, sample button_data into bit index and drop pulse.
  - If index==NUM_BUTTONS-1, go to DONE; otherwise increment index and go to PULSE_LO.
  - Exactly NUM_BUTTONS-1 pulses are generated.
- DONE: one cycle. buttons <= ~shift register; buttons_valid=1 for this cycle only; go to IDLE.
- Timing: the sequence occupies LATCH_CYCLES + 2*HALF_CYCLES*(NUM_BUTTONS-1) cycles (defaults: 3840). buttons_valid rises on the cycle after the sequence ends.
- busy=1 in all states except IDLE.
- latch and pulse are never high simultaneously.
- buttons holds its value between polls.
- Tick while busy: ignored. Required constraint: POLL_CYCLES > sequence length + 1. The bench asserts this at elaboration.
- enable deasserted mid-sequence: the sequence completes and publishes. Later ticks are ignored until enable=1.
- button_data is double-flop synchronised before sampling. Sample points account for the 2-cycle delay, so data sampled is the pin value present at the sample edge minus 2 cycles; the controller holds data for at least 6 us.

Test Plan:
- Reset values: assert reset for 5 cycles, then release with enable=0 -> all outputs 0. No latch over 2 poll periods (use POLL_CYCLES=5000, LATCH_CYCLES=12, HALF_CYCLES=6 for sim).
- Timing: enable=1 with sim parameters -> latch rises 1 cycle after tick and stays high exactly 12 cycles. Then 7 pulses, each 6 low and 6 high. buttons_valid pulses once, 97 cycles after latch rises. Repeats every 5000 cycles.
- Data: controller model presents raw active-low 8'hA5 (bit0 first) -> buttons=8'h5A with a single-cycle buttons_valid. Next poll, raw 8'hFF -> buttons=8'h00.
- Async reset mid-sequence: pull reset low during the 3rd pulse -> latch=0, pulse=0, busy=0 immediately. buttons remains 0 with no valid strobe. After release, the next read starts at the next tick.
- Enable drop: deassert enable during LATCH -> current sequence completes and publishes. No further latch until enable=1, and that new read begins on the following tick.
- Hold: across 10 polls with constant raw 8'hFE -> buttons stays 8'h01. buttons_valid is high exactly 10 cycles total.

Source files
------------

// File: rtl/nes_pad_reader.sv
// nes_pad_reader
// Polls an NES controller once per poll period. It drives the latch pulse and
// the serial clock pulses, and samples the active-low serial data line after a
// two-flop synchroniser. The result is published as a registered, active-high
// button vector with a one-cycle valid strobe. Bit order: 0=A, 1=B, 2=Select,
// 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
module nes_pad_reader #(
    parameter int unsigned POLL_CYCLES  = 666666,
    parameter int unsigned LATCH_CYCLES = 480,
    parameter int unsigned HALF_CYCLES  = 240,
    parameter int unsigned NUM_BUTTONS  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   button_data,
    output logic                   latch,
    output logic                   pulse,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic                   buttons_valid,
    output logic                   busy
);

    // ------------------------------------------------------------------
    // Derived widths and terminal counts
    // ------------------------------------------------------------------
    localparam int unsigned TW      = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IW      = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
    localparam logic [IW-1:0] IDX_FIRST  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_BUTTONS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        PULSE_LO,
        PULSE_HI,
        DONE
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [TW-1:0]          timer_q, timer_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_BUTTONS-1:0] shift_q, shift_d;
    logic                   sync1_q, sync2_q;
    logic                   latch_q, latch_d;
    logic                   pulse_q, pulse_d;
    logic [NUM_BUTTONS-1:0] buttons_q, buttons_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    logic                   tick;

    // ------------------------------------------------------------------
    // Poll timer: free-running, independent of enable and of the FSM
    // ------------------------------------------------------------------
    assign tick = (timer_q == TIMER_LAST);

    // Next value of the poll timer, wrapping after the tick cycle.
    always_comb begin
        timer_d = timer_q + TW'(1);
        if (tick) begin
            timer_d = '0;
        end
    end

    // Poll timer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // ------------------------------------------------------------------
    // Serial data synchroniser (pin idles high = not pressed)
    // ------------------------------------------------------------------
    // Two-flop synchroniser on the asynchronous controller data line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= button_data;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------
    // Next-state logic: counts cycles inside each phase and shifts in one
    // data bit at the end of the latch phase and at the end of every high
    // pulse phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;

        case (state_q)
            IDLE: begin
                // Ticks while a read is running never reach here, so they
                // are ignored by construction.
                if (tick && enable) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end

            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    shift_d[0] = sync2_q;
                    idx_d      = IDX_FIRST;
                    cnt_d      = '0;
                    state_d    = PULSE_LO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            PULSE_LO: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = PULSE_HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            PULSE_HI: begin
                if (cnt_q == HALF_LAST) begin
                    shift_d[idx_q] = sync2_q;
                    cnt_d          = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = PULSE_LO;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    // Pin and status outputs decode the next state so they line up with the
    // state register; results publish out of DONE, one cycle after the
    // final sample edge.
    always_comb begin
        latch_d   = (state_d == LATCH);
        pulse_d   = (state_d == PULSE_HI);
        busy_d    = (state_d != IDLE);
        valid_d   = 1'b0;
        buttons_d = buttons_q;
        if (state_q == DONE) begin
            valid_d   = 1'b1;
            buttons_d = ~shift_q;
        end
    end

    // Output register; reset clears everything so an aborted read never
    // publishes a partial result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            buttons_q <= '0;
        end else begin
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            buttons_q <= buttons_d;
        end
    end

    assign latch         = latch_q;
    assign pulse         = pulse_q;
    assign busy          = busy_q;
    assign buttons_valid = valid_q;
    assign buttons       = buttons_q;

endmodule
